alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 53 +++++
 rtl/alu_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the two-port ALU arbiter: two request channels
// carrying an ALU operation and two response channels returning the result.
interface alu_arbiter_if #(
    parameter int WORD_SIZE = 256,
    parameter int INSN      = 19,
    parameter int IADDR     = 10
);
    // requester 0
    logic                 req0_valid;
    logic                 req0_ready;
    logic                 req0_lock;
    logic [INSN:0]        req0_insn;
    logic [IADDR:0]       req0_pc;
    logic [WORD_SIZE-1:0] req0_r1data;
    logic [WORD_SIZE-1:0] req0_r2data;
    logic                 req0_carry;
    logic                 rsp0_valid;
    logic                 rsp0_ready;
    logic [WORD_SIZE-1:0] rsp0_result;

    // requester 1
    logic                 req1_valid;
    logic                 req1_ready;
    logic                 req1_lock;
    logic [INSN:0]        req1_insn;
    logic [IADDR:0]       req1_pc;
    logic [WORD_SIZE-1:0] req1_r1data;
    logic [WORD_SIZE-1:0] req1_r2data;
    logic                 req1_carry;
    logic                 rsp1_valid;
    logic                 rsp1_ready;
    logic [WORD_SIZE-1:0] rsp1_result;

    // requesters drive operations and response-ready
    modport master (
        output req0_valid, req0_lock, req0_insn, req0_pc, req0_r1data, req0_r2data, req0_carry,
        output rsp0_ready,
        input  req0_ready, rsp0_valid, rsp0_result,
        output req1_valid, req1_lock, req1_insn, req1_pc, req1_r1data, req1_r2data, req1_carry,
        output rsp1_ready,
        input  req1_ready, rsp1_valid, rsp1_result
    );

    // arbiter accepts operations and returns results
    modport slave (
        input  req0_valid, req0_lock, req0_insn, req0_pc, req0_r1data, req0_r2data, req0_carry,
        input  rsp0_ready,
        output req0_ready, rsp0_valid, rsp0_result,
        input  req1_valid, req1_lock, req1_insn, req1_pc, req1_r1data, req1_r2data, req1_carry,
        input  rsp1_ready,
        output req1_ready, rsp1_valid, rsp1_result
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters. One operation is in
// flight at a time: IDLE (arbitrate/accept) -> ISSUE (drive ALU, capture
// result) -> RESP (hold result until the owner takes it). A requester may set
// lock on an accepted op to keep the grant for its next op while it is valid.
module alu_arbiter #(
    parameter int WORD_SIZE = 256,
    parameter int INSN      = 19,
    parameter int IADDR     = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_arbiter_if.slave         bus,
    output logic [INSN:0]        alu_insn,
    output logic [IADDR:0]       alu_pc,
    output logic [WORD_SIZE-1:0] alu_r1data,
    output logic [WORD_SIZE-1:0] alu_r2data,
    output logic                 alu_carry,
    input  logic [WORD_SIZE-1:0] alu_result,
    output logic                 busy,
    output logic [15:0]          issue_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [INSN:0]        insn;
        logic [IADDR:0]       pc;
        logic [WORD_SIZE-1:0] r1data;
        logic [WORD_SIZE-1:0] r2data;
        logic                 carry;
    } op_t;

    state_t               state, state_nxt;
    op_t                  req0_op, req1_op, sel_op, op_q;
    logic                 grant, accept, sel_lock, idle, issuing, responding;
    logic                 last_grant, lock_active, lock_owner, owner;
    logic                 owner_rsp_ready;
    logic [WORD_SIZE-1:0] result_q;

    assign req0_op = {bus.req0_insn, bus.req0_pc, bus.req0_r1data, bus.req0_r2data, bus.req0_carry};
    assign req1_op = {bus.req1_insn, bus.req1_pc, bus.req1_r1data, bus.req1_r2data, bus.req1_carry};

    assign idle       = (state == IDLE);
    assign issuing    = (state == ISSUE);
    assign responding = (state == RESP);

    // Grant: a valid lock holder wins; otherwise the sole valid requester;
    // otherwise (both or neither valid) whoever was not granted last. A lock
    // whose owner has gone idle does not block the other side.
    always_comb begin
        grant = ~last_grant;
        if (lock_active && (lock_owner ? bus.req1_valid : bus.req0_valid))
            grant = lock_owner;
        else if (bus.req0_valid && !bus.req1_valid)
            grant = 1'b0;
        else if (bus.req1_valid && !bus.req0_valid)
            grant = 1'b1;
    end

    assign bus.req0_ready = idle && !grant;
    assign bus.req1_ready = idle &&  grant;

    assign accept   = grant ? (bus.req1_valid && bus.req1_ready)
                            : (bus.req0_valid && bus.req0_ready);
    assign sel_op   = grant ? req1_op : req0_op;
    assign sel_lock = grant ? bus.req1_lock : bus.req0_lock;

    assign owner_rsp_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;

    // Next-state: one accept per op, exactly one ISSUE cycle, RESP until taken
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    if (owner_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset drops any op in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Capture the winning op and update arbitration history on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            lock_active <= 1'b0;
            lock_owner  <= 1'b0;
        end else if (accept) begin
            op_q        <= sel_op;
            owner       <= grant;
            last_grant  <= grant;
            lock_active <= sel_lock;
            lock_owner  <= grant;
        end
    end

    // Register the ALU result and count the issue at the end of ISSUE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            issue_count <= '0;
        end else if (issuing) begin
            result_q    <= alu_result;
            issue_count <= issue_count + 16'd1;
        end
    end

    // ALU sees a NOP (all zero) except during the single ISSUE cycle
    assign alu_insn   = issuing ? op_q.insn   : '0;
    assign alu_pc     = issuing ? op_q.pc     : '0;
    assign alu_r1data = issuing ? op_q.r1data : '0;
    assign alu_r2data = issuing ? op_q.r2data : '0;
    assign alu_carry  = issuing ? op_q.carry  : 1'b0;

    // Response goes only to the owner; the other channel stays zero
    assign bus.rsp0_valid  = responding && !owner;
    assign bus.rsp1_valid  = responding &&  owner;
    assign bus.rsp0_result = bus.rsp0_valid ? result_q : '0;
    assign bus.rsp1_result = bus.rsp1_valid ? result_q : '0;

    assign busy = !idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter. The stimulus side drives the
// two request channels; a negedge monitor predicts grants from the arbitration
// rules, pushes the expected result on each accept and pops/compares when the
// owner's response is taken.
module tb_alu_arbiter;
    localparam int WS = 64;
    localparam int IN = 19;
    localparam int IA = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IN:0]   alu_insn;
    logic [IA:0]   alu_pc;
    logic [WS-1:0] alu_r1data, alu_r2data, alu_result;
    logic          alu_carry, busy;
    logic [15:0]   issue_count;

    alu_arbiter_if #(.WORD_SIZE(WS), .INSN(IN), .IADDR(IA)) bus ();

    alu_arbiter #(.WORD_SIZE(WS), .INSN(IN), .IADDR(IA)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_insn   (alu_insn),
        .alu_pc     (alu_pc),
        .alu_r1data (alu_r1data),
        .alu_r2data (alu_r2data),
        .alu_carry  (alu_carry),
        .alu_result (alu_result),
        .busy       (busy),
        .issue_count(issue_count)
    );

    typedef struct {
        logic [IN:0]   insn;
        logic [IA:0]   pc;
        logic [WS-1:0] r1;
        logic [WS-1:0] r2;
        logic          carry;
    } op_t;

    typedef struct {
        bit            owner;
        logic [WS-1:0] result;
    } exp_t;

    exp_t        exp_q[$];
    bit          grant_log[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    // model state of the arbiter as seen from outside
    bit          m_busy = 0, m_last = 1, m_lock = 0, m_lock_owner = 0;
    bit          in_issue = 0, rsp_seen = 0;
    logic [15:0] m_count = 16'd0;
    op_t         cur;
    int          acc_cyc = 0;

    // Stand-in ALU: a few opcodes in insn[19:15]
    function automatic logic [WS-1:0] ref_alu(logic [IN:0] insn, logic [IA:0] pc,
                                              logic [WS-1:0] a, logic [WS-1:0] b, logic c);
        case (insn[IN -: 5])
            5'b00101: return a + b + WS'(c);
            5'b00110: return a - b - WS'(c);
            5'b01000: return a & b;
            default:  return a ^ b ^ WS'(pc);
        endcase
    endfunction

    assign alu_result = ref_alu(alu_insn, alu_pc, alu_r1data, alu_r2data, alu_carry);

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    task automatic chk(string name, logic [WS-1:0] got, logic [WS-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic op_t rand_op();
        op_t o;
        o.insn = IN'($urandom);
        case ($urandom_range(3))
            0: o.insn[IN -: 5] = 5'b00101;
            1: o.insn[IN -: 5] = 5'b00110;
            2: o.insn[IN -: 5] = 5'b01000;
            default: ;
        endcase
        o.pc    = IA'($urandom);
        o.r1    = {$urandom, $urandom};
        o.r2    = {$urandom, $urandom};
        o.carry = 1'($urandom);
        return o;
    endfunction

    function automatic op_t get_op(bit n);
        op_t o;
        if (!n) begin
            o.insn = bus.req0_insn; o.pc = bus.req0_pc; o.r1 = bus.req0_r1data;
            o.r2 = bus.req0_r2data; o.carry = bus.req0_carry;
        end else begin
            o.insn = bus.req1_insn; o.pc = bus.req1_pc; o.r1 = bus.req1_r1data;
            o.r2 = bus.req1_r2data; o.carry = bus.req1_carry;
        end
        return o;
    endfunction

    task automatic drive(bit n, bit v, bit lk, op_t o);
        if (!n) begin
            bus.req0_valid = v; bus.req0_lock = lk; bus.req0_insn = o.insn; bus.req0_pc = o.pc;
            bus.req0_r1data = o.r1; bus.req0_r2data = o.r2; bus.req0_carry = o.carry;
        end else begin
            bus.req1_valid = v; bus.req1_lock = lk; bus.req1_insn = o.insn; bus.req1_pc = o.pc;
            bus.req1_r1data = o.r1; bus.req1_r2data = o.r2; bus.req1_carry = o.carry;
        end
    endtask

    // Monitor + scoreboard
    initial begin : monitor
        bit   issue_now, g, v0, v1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                m_busy = 0; m_last = 1; m_lock = 0; m_lock_owner = 0;
                m_count = 16'd0; in_issue = 0;
                continue;
            end
            issue_now = in_issue;
            in_issue  = 0;
            if (issue_now) begin
                chk("alu_insn", alu_insn, cur.insn);
                chk("alu_pc", alu_pc, cur.pc);
                chk("alu_r1", alu_r1data, cur.r1);
                chk("alu_r2", alu_r2data, cur.r2);
                chk("alu_carry", alu_carry, cur.carry);
            end else begin
                chk("alu_ctl_zero", {alu_insn, alu_pc, alu_carry}, 0);
                chk("alu_r1_zero", alu_r1data, 0);
                chk("alu_r2_zero", alu_r2data, 0);
            end
            chk("busy", busy, m_busy);
            if (!m_busy) begin
                v0 = bus.req0_valid;
                v1 = bus.req1_valid;
                if (m_lock && (m_lock_owner ? v1 : v0)) g = m_lock_owner;
                else if (v0 != v1)                      g = v1;
                else                                    g = !m_last;
                chk("req0_ready", bus.req0_ready, !g);
                chk("req1_ready", bus.req1_ready, g);
                chk("rsp_valid_idle", {bus.rsp0_valid, bus.rsp1_valid}, 0);
                if (g ? v1 : v0) begin
                    cur      = get_op(g);
                    e.owner  = g;
                    e.result = ref_alu(cur.insn, cur.pc, cur.r1, cur.r2, cur.carry);
                    exp_q.push_back(e);
                    grant_log.push_back(g);
                    m_lock       = g ? bus.req1_lock : bus.req0_lock;
                    m_lock_owner = g;
                    m_last       = g;
                    m_busy       = 1;
                    in_issue     = 1;
                    m_count      = m_count + 16'd1;
                    acc_cyc      = cyc;
                    rsp_seen     = 0;
                end
            end else begin
                chk("ready_busy", {bus.req0_ready, bus.req1_ready}, 0);
                if (issue_now) begin
                    chk("rsp_valid_issue", {bus.rsp0_valid, bus.rsp1_valid}, 0);
                end else if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    chk("rsp0_valid", bus.rsp0_valid, !e.owner);
                    chk("rsp1_valid", bus.rsp1_valid, e.owner);
                    chk("rsp_result", e.owner ? bus.rsp1_result : bus.rsp0_result, e.result);
                    chk("rsp_other_zero", e.owner ? bus.rsp0_result : bus.rsp1_result, 0);
                    if (!rsp_seen) begin
                        // response appears two edges after the edge opening the accept cycle
                        chk("latency", WS'(cyc - acc_cyc), 2);
                        rsp_seen = 1;
                    end
                    if (e.owner ? bus.rsp1_ready : bus.rsp0_ready) begin
                        chk("issue_count", issue_count, m_count);
                        void'(exp_q.pop_front());
                        m_busy = 0;
                    end
                end
            end
        end
    end

    task automatic wait_accept(bit n);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (n ? (bus.req1_valid && bus.req1_ready) : (bus.req0_valid && bus.req0_ready)) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        chk("accept_seen", ok, 1);
    endtask

    task automatic drain();
        drive(0, 0, 0, rand_op());
        drive(1, 0, 0, rand_op());
        bus.rsp0_ready = 1;
        bus.rsp1_ready = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_busy", busy, 0);
        @(posedge clk); #1;
    endtask

    // Random traffic; the first lock1_ops req1 ops carry lock=1
    task automatic run(int n_acc, int pv0, int pv1, int plk, int prdy, int lock1_ops);
        int acc = 0, l1 = 0;
        bit a0, a1;
        drive(0, $urandom_range(99) < pv0, $urandom_range(99) < plk, rand_op());
        drive(1, $urandom_range(99) < pv1, (lock1_ops > 0) || ($urandom_range(99) < plk), rand_op());
        for (int c = 0; c < 5000 && acc < n_acc; c++) begin
            @(negedge clk);
            a0 = bus.req0_valid && bus.req0_ready;
            a1 = bus.req1_valid && bus.req1_ready;
            @(posedge clk); #1;
            if (a0) acc++;
            if (a1) begin acc++; l1++; end
            if (a0 || !bus.req0_valid)
                drive(0, $urandom_range(99) < pv0, $urandom_range(99) < plk, rand_op());
            if (a1 || !bus.req1_valid)
                drive(1, $urandom_range(99) < pv1, (l1 < lock1_ops) || ($urandom_range(99) < plk), rand_op());
            bus.rsp0_ready = $urandom_range(99) < prdy;
            bus.rsp1_ready = $urandom_range(99) < prdy;
        end
        chk("run_accepts", acc, n_acc);
        drain();
    endtask

    initial begin : stim
        op_t o;
        drive(0, 0, 0, rand_op());
        drive(1, 0, 0, rand_op());
        bus.rsp0_ready = 1;
        bus.rsp1_ready = 1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req0_ready", bus.req0_ready, 1);
        chk("rst_req1_ready", bus.req1_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", issue_count, 0);
        chk("rst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 0);
        chk("rst_rsp_result", bus.rsp0_result | bus.rsp1_result, 0);
        chk("rst_alu", {alu_insn, alu_pc, alu_carry}, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // single ADD from req0
        o.insn = 20'h28000; o.pc = 11'h0; o.r1 = 64'd5; o.r2 = 64'd7; o.carry = 1'b0;
        drive(0, 1, 0, o);
        wait_accept(0);
        drive(0, 0, 0, rand_op());
        @(negedge clk);
        chk("add_alu_insn", alu_insn, 20'h28000);
        @(negedge clk);
        chk("add_rsp_valid", bus.rsp0_valid, 1);
        chk("add_rsp_result", bus.rsp0_result, 64'd12);
        drain();
        chk("add_count", issue_count, 1);

        // reset while an op is in ISSUE
        drive(0, 1, 0, rand_op());
        wait_accept(0);
        drive(0, 0, 0, rand_op());
        rst_n = 0;
        #1;
        chk("rst_issue_busy", busy, 0);
        chk("rst_issue_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 0);
        chk("rst_issue_count", issue_count, 0);
        chk("rst_issue_alu", alu_insn, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_issue_no_rsp", {bus.rsp0_valid, bus.rsp1_valid, busy}, 0);
        chk("rst_issue_count_after", issue_count, 0);

        // both valid, no lock: strict alternation starting with req0
        grant_log.delete();
        run(4, 100, 100, 0, 100, 0);
        chk("alt_len", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk($sformatf("alt_grant%0d", i), grant_log[i], i % 2);

        // req1 holds lock across its first two ops; req0 waits
        grant_log.delete();
        run(5, 100, 100, 0, 100, 2);
        chk("lock_len", grant_log.size(), 5);
        if (grant_log.size() == 5) begin
            chk("lock_seq", {grant_log[0], grant_log[1], grant_log[2], grant_log[3], grant_log[4]}, 5'b01110);
        end

        // backpressure: owner holds rsp0_ready low for 5 cycles
        bus.rsp0_ready = 0;
        drive(0, 1, 0, rand_op());
        wait_accept(0);
        drive(0, 0, 0, rand_op());
        drive(1, 1, 0, rand_op());
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", bus.rsp0_valid, 1);
            chk("bp_ready", {bus.req0_ready, bus.req1_ready}, 0);
            chk("bp_busy", busy, 1);
        end
        @(posedge clk); #1;
        bus.rsp0_ready = 1;
        wait_accept(1);
        drain();

        // random traffic with random locks and backpressure
        run(150, 70, 70, 30, 70, 0);
        run(100, 40, 90, 50, 40, 0);

        // counter wrap
        force dut.issue_count = 16'hFFFF;
        @(negedge clk);
        release dut.issue_count;
        #1;
        m_count = 16'hFFFF;
        chk("count_preset", issue_count, 16'hFFFF);
        @(posedge clk); #1;
        drive(1, 1, 0, rand_op());
        wait_accept(1);
        drain();
        chk("count_wrap", issue_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
